stopwatch_input_conditioner: RTL and testbench

Conditions the four raw board inputs of the stopwatch (reset button, pause button, SELECT switch, ADJUST switch) before they reach the time-keeping stage. Each input is synchronised, debounced by a stability counter, and converted into a clean level and/or a single-cycle event. The block also owns the run/pause state, so downstream logic receives a `run` level and a `clear` pulse instead of raw button activity. It sits directly upstream of the time-counting stage and runs on the master clock.

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/debounce_channel.sv | 74 +++++++
 rtl/stopwatch_input_conditioner.sv | 92 +++++++++
 tb/tb_stopwatch_input_conditioner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front end.
//   run_state_e             : run/pause state of the stopwatch
//   DEFAULT_DEBOUNCE_CYCLES : default stability window (10 ms at 100 MHz)
package stopwatch_pkg;

   typedef enum logic {
      PAUSED  = 1'b0,
      RUNNING = 1'b1
   } run_state_e;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage : stopwatch_pkg

// File: rtl/debounce_channel.sv
// One conditioning channel: two-flop synchroniser, stability counter and
// registered edge pulses.
//   clk, rst_n : master clock, asynchronous active-low reset
//   din        : raw asynchronous input
//   level      : accepted (debounced) level
//   rise, fall : one-cycle pulses, high in the first cycle the new level is seen
module debounce_channel
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every signal gets a default at the top of the block so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      s1_d     = din;
      s2_d     = s1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      // The count only advances while s2 disagrees with the accepted level;
      // any return to agreement drops it back to zero, so it never wraps.
      if (s2_q != stable_q) begin
         if (cnt_q == TERM_CNT) begin
            stable_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      rise_d = stable_d & ~stable_q;
      fall_d = ~stable_d & stable_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign level = stable_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule : debounce_channel

// File: rtl/stopwatch_input_conditioner.sv
// Conditions the four raw stopwatch inputs and owns the run/pause state.
//   clk, rst_n : master clock, asynchronous active-low reset
//   btn_reset  : raw reset button  -> clear (one pulse per accepted press)
//   btn_pause  : raw pause button  -> pause_evt (one pulse per accepted press)
//   sw_sel     : raw SELECT switch -> sel (debounced level)
//   sw_adj     : raw ADJUST switch -> adj (debounced level)
//   run        : 1 while counting, 0 while paused
module stopwatch_input_conditioner
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_reset,
   input  logic btn_pause,
   input  logic sw_sel,
   input  logic sw_adj,
   output logic sel,
   output logic adj,
   output logic clear,
   output logic run,
   output logic pause_evt
);

   // Button levels and release edges, and switch edges, have no consumer.
   logic unused_reset_level, unused_reset_fall;
   logic unused_pause_level, unused_pause_fall;
   logic unused_sel_rise, unused_sel_fall;
   logic unused_adj_rise, unused_adj_fall;

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (btn_reset),
      .level (unused_reset_level),
      .rise  (clear),
      .fall  (unused_reset_fall)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (btn_pause),
      .level (unused_pause_level),
      .rise  (pause_evt),
      .fall  (unused_pause_fall)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sw_sel),
      .level (sel),
      .rise  (unused_sel_rise),
      .fall  (unused_sel_fall)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adj_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sw_adj),
      .level (adj),
      .rise  (unused_adj_rise),
      .fall  (unused_adj_fall)
   );

   run_state_e state_q, state_d;

   // clear takes priority so a simultaneous pause press cannot start the watch.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = PAUSED;
      end else if (pause_evt) begin
         state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
      end
   end

   // NOTE: only control state is reset here; there is no storage array in this
   // block, so every register can take the asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PAUSED;
      end else begin
         state_q <= state_d;
      end
   end

   assign run = (state_q == RUNNING);

endmodule : stopwatch_input_conditioner

// File: tb/tb_stopwatch_input_conditioner.sv
// Directed bench for stopwatch_input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs are driven and outputs sampled on the falling clock edge. Expected
// output vectors {sel, adj, clear, run, pause_evt} are queued with the cycle
// at which they must appear and compared when that cycle is reached.
// An input driven at falling edge c is captured by s1 at the next rising edge
// N; the accepted level (and rise pulse) appear after edge N+5, i.e. at the
// sample of falling edge c+6, and run follows at c+7.
module tb_stopwatch_input_conditioner;

   localparam int DC = 4;

   logic clk;
   logic rst_n;
   logic btn_reset, btn_pause, sw_sel, sw_adj;
   logic sel, adj, clear, run, pause_evt;

   stopwatch_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_reset (btn_reset),
      .btn_pause (btn_pause),
      .sw_sel    (sw_sel),
      .sw_adj    (sw_adj),
      .sel       (sel),
      .adj       (adj),
      .clear     (clear),
      .run       (run),
      .pause_evt (pause_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      string      tag;
      logic [4:0] vec;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_cmp;
   int   n_mis;

   function automatic logic [4:0] v5(input logic s, input logic a, input logic c,
                                     input logic r, input logic p);
      return {s, a, c, r, p};
   endfunction

   function automatic void exp_at(input int off, input string tag, input logic [4:0] v);
      exp_t e;
      e.cyc = cyc + off;
      e.tag = tag;
      e.vec = v;
      sb.push_back(e);
   endfunction

   function automatic void exp_span(input int from, input int to, input string tag,
                                    input logic [4:0] v);
      for (int k = from; k <= to; k++) exp_at(k, tag, v);
   endfunction

   task automatic compare_due();
      exp_t       e;
      logic [4:0] obs;
      obs = {sel, adj, clear, run, pause_evt};
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_cmp++;
         assert (obs === e.vec) else begin
            n_mis++;
            $error("FAIL %s cyc=%0d: observed {sel,adj,clear,run,pause_evt}=%b expected %b",
                   e.tag, cyc, obs, e.vec);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      compare_due();
   endtask

   initial begin
      int rb, ra;
      cyc   = 0;
      n_cmp = 0;
      n_mis = 0;
      rst_n = 1'b1;
      btn_reset = 1'b1;
      btn_pause = 1'b1;
      sw_sel    = 1'b1;
      sw_adj    = 1'b1;
      #2 rst_n = 1'b0;

      // Reset held with every input high: all outputs low.
      exp_span(1, 3, "reset_hold", v5(0, 0, 0, 0, 0));
      repeat (3) tick();

      // Release with only SELECT still high; sel appears after the full latency.
      rst_n     = 1'b1;
      btn_reset = 1'b0;
      btn_pause = 1'b0;
      sw_adj    = 1'b0;
      exp_span(1, 5, "sel_wait", v5(0, 0, 0, 0, 0));
      exp_at(6, "sel_rise", v5(1, 0, 0, 0, 0));
      exp_at(7, "sel_hold", v5(1, 0, 0, 0, 0));
      repeat (7) tick();

      // ADJUST bouncing with 2-cycle pulses never reaches the terminal count.
      for (int i = 0; i < 10; i++) begin
         sw_adj = (i % 2 == 0);
         exp_span(1, 2, "adj_bounce", v5(1, 0, 0, 0, 0));
         repeat (2) tick();
      end
      sw_adj = 1'b1;
      exp_span(1, 5, "adj_wait", v5(1, 0, 0, 0, 0));
      exp_span(6, 8, "adj_rise", v5(1, 1, 0, 0, 0));
      repeat (8) tick();

      // Three clean pause presses: run goes 0->1->0->1, releases are silent.
      for (int p = 0; p < 3; p++) begin
         rb = p % 2;
         ra = 1 - rb;
         btn_pause = 1'b1;
         exp_span(1, 5, "pause_wait", v5(1, 1, 0, rb[0], 0));
         exp_at(6, "pause_pulse", v5(1, 1, 0, rb[0], 1));
         exp_span(7, 10, "pause_held", v5(1, 1, 0, ra[0], 0));
         repeat (10) tick();
         btn_pause = 1'b0;
         exp_span(1, 10, "pause_release", v5(1, 1, 0, ra[0], 0));
         repeat (10) tick();
      end

      // Clear while running; a 50-cycle hold produces a single pulse.
      btn_reset = 1'b1;
      exp_span(1, 5, "clear_wait", v5(1, 1, 0, 1, 0));
      exp_at(6, "clear_pulse", v5(1, 1, 1, 1, 0));
      exp_span(7, 50, "clear_held", v5(1, 1, 0, 0, 0));
      repeat (50) tick();
      btn_reset = 1'b0;
      exp_span(1, 10, "clear_release", v5(1, 1, 0, 0, 0));
      repeat (10) tick();

      // Simultaneous reset and pause presses while paused: clear wins.
      btn_reset = 1'b1;
      btn_pause = 1'b1;
      exp_span(1, 5, "both_wait", v5(1, 1, 0, 0, 0));
      exp_at(6, "both_pulse", v5(1, 1, 1, 0, 1));
      exp_span(7, 10, "both_held", v5(1, 1, 0, 0, 0));
      repeat (10) tick();
      btn_reset = 1'b0;
      btn_pause = 1'b0;
      exp_span(1, 10, "both_release", v5(1, 1, 0, 0, 0));
      repeat (10) tick();

      // Pause press interrupted by reset when its counter holds 2.
      btn_pause = 1'b1;
      exp_span(1, 4, "midrst_count", v5(1, 1, 0, 0, 0));
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      exp_at(0, "midrst_async", v5(0, 0, 0, 0, 0));
      compare_due();
      exp_span(1, 2, "midrst_hold", v5(0, 0, 0, 0, 0));
      repeat (2) tick();
      rst_n = 1'b1;
      exp_span(1, 5, "midrst_wait", v5(0, 0, 0, 0, 0));
      exp_at(6, "midrst_pulse", v5(1, 1, 0, 0, 1));
      exp_span(7, 15, "midrst_after", v5(1, 1, 0, 1, 0));
      repeat (15) tick();

      n_cmp++;
      assert (sb.size() == 0) else begin
         n_mis++;
         $error("FAIL sb_drain: observed %0d pending expectations, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_stopwatch_input_conditioner
